// File: rtl/demux1x4_reg_pkg.sv
// rtl/demux1x4_reg_pkg.sv - shared widths, channel indices and state type for the 1-to-4 demux
package demux1x4_reg_pkg;

    localparam int TAM_DEF = 16;
    localparam int SEL_W   = 2;

    typedef logic [SEL_W-1:0] sel_t;

    localparam sel_t CH0 = 2'd0;
    localparam sel_t CH1 = 2'd1;
    localparam sel_t CH2 = 2'd2;
    localparam sel_t CH3 = 2'd3;

    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } state_t;

endpackage

// File: rtl/demux1x4_reg_dec2x4.sv
// rtl/demux1x4_reg_dec2x4.sv - 2-to-4 one-hot decoder with enable
module demux1x4_reg_dec2x4
    import demux1x4_reg_pkg::*;
(
    input  logic       en,
    input  sel_t       sel,
    output logic [3:0] onehot
);

    always_comb begin
        onehot = 4'b0000;
        if (en) begin
            onehot[sel] = 1'b1;
        end
    end

endmodule

// File: rtl/demux1x4_reg.sv
// rtl/demux1x4_reg.sv - registered 1-to-4 demultiplexer, single output stage with valid/ready
module demux1x4_reg
    import demux1x4_reg_pkg::*;
#(
    parameter int TAM = TAM_DEF
) (
    input  logic           clk,
    input  logic           rst,
    input  logic [TAM-1:0] DEMUX_in,
    input  logic [1:0]     DEMUX_sel,
    input  logic           DEMUX_in_valid,
    output logic           DEMUX_in_ready,
    output logic [TAM-1:0] DEMUX_out0,
    output logic [TAM-1:0] DEMUX_out1,
    output logic [TAM-1:0] DEMUX_out2,
    output logic [TAM-1:0] DEMUX_out3,
    output logic [3:0]     DEMUX_out_valid,
    input  logic [3:0]     DEMUX_out_ready,
    output logic [7:0]     DEMUX_count
);

    state_t         state_q;
    state_t         state_d;
    logic [TAM-1:0] data_q;
    sel_t           sel_q;
    logic [7:0]     count_q;

    logic full;
    logic deliver;
    logic accept;

    assign full    = (state_q == ST_FULL);
    // Only the ready bit of the channel currently holding the word matters.
    assign deliver = full & DEMUX_out_ready[sel_q];
    assign DEMUX_in_ready = ~full | deliver;
    assign accept  = DEMUX_in_valid & DEMUX_in_ready;

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_EMPTY: if (accept) state_d = ST_FULL;
            ST_FULL:  if (deliver && !accept) state_d = ST_EMPTY;
            default:  state_d = ST_EMPTY;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_EMPTY;
            data_q  <= '0;
            sel_q   <= CH0;
            count_q <= 8'd0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                data_q <= DEMUX_in;
                sel_q  <= DEMUX_sel;
            end
            if (deliver) begin
                count_q <= count_q + 8'd1;
            end
        end
    end

    demux1x4_reg_dec2x4 u_dec (
        .en     (full),
        .sel    (sel_q),
        .onehot (DEMUX_out_valid)
    );

    // Unselected channels are gated to zero, mirroring the AND-OR mux.
    assign DEMUX_out0 = DEMUX_out_valid[CH0] ? data_q : '0;
    assign DEMUX_out1 = DEMUX_out_valid[CH1] ? data_q : '0;
    assign DEMUX_out2 = DEMUX_out_valid[CH2] ? data_q : '0;
    assign DEMUX_out3 = DEMUX_out_valid[CH3] ? data_q : '0;

    assign DEMUX_count = count_q;

endmodule
